// File: rtl/mips8_ctrl_pkg.sv
// Shared encodings for the 8-bit multicycle processor control unit:
// state codes, opcodes, ALU/mux select constants and the control bundle.
package mips8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control decoder; Moore outputs except the
// fetch-time IR/PC loads, which follow mem_ready.
module multicycle_ctrl_decode
  import mips8_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_BOFF;
        ctrl.illegal_op = !is_known_op(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle processor: state register, opcode
// latch and next-state logic; output decode lives in multicycle_ctrl_decode.
module multicycle_control
  import mips8_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     state;
  state_t     state_n;
  logic [5:0] op_q;
  ctrl_t      ctrl;
  ctrl_t      ctrl_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      op_q  <= OP_RTYPE;
    end else begin
      state <= state_n;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_n = S_EXEC;
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_BEQ:       state_n = S_BRANCH;
          OP_J:         state_n = S_JUMP;
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR: state_n = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_n = S_FETCH;
      S_EXEC:   state_n = S_ALUWB;
      S_ADDIEX: state_n = S_ADDIWB;
      default:  state_n = S_FETCH;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset masks the FETCH decode so nothing (mem_req included) leaks out while rst_n is low.
  assign ctrl_g = rst_n ? ctrl : '0;

  assign mem_req     = ctrl_g.mem_req;
  assign IorD        = ctrl_g.iord;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign IRWrite     = ctrl_g.ir_write;
  assign RegDst      = ctrl_g.reg_dst;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign RegWrite    = ctrl_g.reg_write;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign ALUOp       = ctrl_g.alu_op;
  assign PCSource    = ctrl_g.pc_source;
  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign illegal_op  = ctrl_g.illegal_op;
  assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: each instruction is expanded into an expected
// per-cycle trace (state + control vector) and replayed against the DUT.
module tb_multicycle_control;
  import mips8_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
  logic       RegWrite, ALUSrcA, PCWrite, PCWriteCond, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_dbg;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       pc_write, pc_write_cond, illegal_op;
  } exp_t;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic [5:0] op;
    exp_t       e;
  } step_t;

  step_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, want);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o = '{mem_req, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
          RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond,
          illegal_op};
    return o;
  endfunction

  // Non-DECODE cycles carry a random opcode and, where memory is not
  // involved, a random mem_ready: both must be ignored by the DUT.
  task automatic push(input state_t st, input logic mr, input exp_t e);
    step_t s;
    s.st = st; s.mr = mr; s.op = 6'($urandom); s.e = e;
    q.push_back(s);
  endtask

  task automatic plan(input logic [5:0] op, input int fw, input int mw);
    exp_t e;
    step_t s;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.mem_req = 1; e.mem_read = 1; e.alu_src_b = 2'b01;
      e.ir_write = (i == fw); e.pc_write = (i == fw);
      push(S_FETCH, i == fw, e);
    end
    e = '0; e.alu_src_b = 2'b11;
    e.illegal_op = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010});
    s.st = S_DECODE; s.mr = 1'($urandom); s.op = op; s.e = e;
    q.push_back(s);
    if (op == 6'b000000) begin
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b00; e.alu_op = 2'b10;
      push(S_EXEC, 1'($urandom), e);
      e = '0; e.reg_write = 1; e.reg_dst = 1;
      push(S_ALUWB, 1'($urandom), e);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
      push(S_MEMADR, 1'($urandom), e);
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.mem_req = 1; e.iord = 1;
        if (op == 6'b100011) begin
          e.mem_read = 1; push(S_MEMRD, i == mw, e);
        end else begin
          e.mem_write = 1; push(S_MEMWR, i == mw, e);
        end
      end
      if (op == 6'b100011) begin
        e = '0; e.reg_write = 1; e.mem_to_reg = 1;
        push(S_MEMWB, 1'($urandom), e);
      end
    end else if (op == 6'b001000) begin
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
      push(S_ADDIEX, 1'($urandom), e);
      e = '0; e.reg_write = 1;
      push(S_ADDIWB, 1'($urandom), e);
    end else if (op == 6'b000100) begin
      e = '0; e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01;
      push(S_BRANCH, 1'($urandom), e);
    end else if (op == 6'b000010) begin
      e = '0; e.pc_write = 1; e.pc_source = 2'b10;
      push(S_JUMP, 1'($urandom), e);
    end
  endtask

  // Entered just after a rising edge; leaves just after the rising edge
  // that follows the last checked cycle.
  task automatic run_q(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      opcode = s.op;
      mem_ready = s.mr;
      @(negedge clk);
      check($sformatf("%s.state", tag), 32'(state_dbg), 32'(s.st));
      check($sformatf("%s.ctrl.st%0d", tag, s.st), 32'(observed()), 32'(s.e));
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] r;
    case ($urandom_range(0, 6))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b001000;
      4: return 6'b000100;
      5: return 6'b000010;
      default: begin
        r = 6'($urandom);
        while (r inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010})
          r = 6'($urandom);
        return r;
      end
    endcase
  endfunction

  function automatic int pick_wait();
    return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    opcode = 6'b000000;
    mem_ready = 1'b1;
    #3;
    check("reset.ctrl", 32'(observed()), 32'd0);
    check("reset.state", 32'(state_dbg), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold.ctrl", 32'(observed()), 32'd0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    plan(6'b000000, 0, 0); run_q("rtype");
    plan(6'b100011, 0, 2); run_q("lw_wait2");
    plan(6'b101011, 0, 1); run_q("sw");
    plan(6'b000100, 0, 0); run_q("beq");
    plan(6'b000010, 0, 0); run_q("j");
    plan(6'b111111, 0, 0); run_q("illegal");
    plan(6'b001000, 2, 0); run_q("addi_fwait");

    // Reset in the middle of a stalled store.
    plan(6'b101011, 0, 3);
    void'(q.pop_back());
    run_q("sw_abort");
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort.ctrl", 32'(observed()), 32'd0);
    check("abort.state", 32'(state_dbg), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("abort_hold.ctrl", 32'(observed()), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = '0; e.mem_req = 1; e.mem_read = 1; e.alu_src_b = 2'b01;
    check("release.ctrl", 32'(observed()), 32'(e));
    check("release.state", 32'(state_dbg), 32'd0);

    for (int i = 0; i < 300; i++) begin
      plan(pick_op(), pick_wait(), pick_wait());
      run_q("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
